io_handshake_unit: RTL and testbench
====================================

Name: io_handshake_unit

Overview:
- Peripheral-side responder for the control unit's IN/OUT handshake.
- Debounces the board's confirm key and drives the `enter` level the control unit waits on.
- Captures switch data for `in` instructions and latches register data for `out` instructions onto the display.
- Sits between the board I/O (switches, key, display driver) and the datapath input mux / control unit.

Parameters:
- DATA_W, 32: datapath word width.
- SW_W, 16: number of board switches, SW_W <= DATA_W.
- DEBOUNCE_CYC, 50000: consecutive stable cycles required to accept a key change, >= 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- controleIN  in  1  control unit requests input; held high while waiting.
- controleOUT  in  1  control unit requests output; held high while waiting.
- sw_data  in  SW_W  raw board switches, treated as quasi-static.
- key_raw  in  1  raw confirm key, active-low (0 = pressed), asynchronous.
- dado_out  in  DATA_W  register-bank value to display.
- enter  out  1  handshake level to the control unit.
- dado_in  out  DATA_W  captured input word to the register write mux.
- display_val  out  DATA_W  latched output word for the display driver.
- wait_in  out  1  LED: input awaited.
- wait_out  out  1  LED: output awaited.

Behaviour:
- Reset (async, active-high):
  - All outputs 0.
  - FSM goes to IDLE.
  - Synchronizer flops 1 (released).
  - key_stable 0 (released); debounce counter 0.
- Synchronizer: 2 flops on key_raw. pressed_sync = ~second flop.
- Debouncer:
  - Counter increments each cycle pressed_sync != key_stable; clears when they are equal.
  - When the counter reaches DEBOUNCE_CYC-1 and they still differ: key_stable toggles and the counter clears.
  - Net latency from key_raw edge to key_stable change = 2 + DEBOUNCE_CYC cycles. Shorter glitches are discarded.
- press_edge = key_stable 0->1 this cycle. release_edge = key_stable 1->0 this cycle.
- FSM states:
  - IDLE:
    - controleIN=1 -> WAIT_IN. controleIN has priority if both requests are high.
    - else controleOUT=1 -> WAIT_OUT, and display_val <= dado_out on the same edge.
    - press_edge in IDLE is discarded.
  - WAIT_IN: wait_in=1. On press_edge:
    - dado_in <= zero-extended sw_data;
    - enter <= 1;
    - -> WAIT_REL.
  - WAIT_OUT: wait_out=1. On press_edge: enter <= 1; -> WAIT_REL. display_val is unchanged.
  - WAIT_REL: enter stays 1. On release_edge: enter <= 0; -> IDLE.
- The request line is not required to stay high in WAIT_REL; its value there is ignored.
- If the request drops in WAIT_IN or WAIT_OUT before a press: -> IDLE with no capture and enter stays 0.
- A key already held when a request arrives is not accepted. A release followed by a fresh press is required.
- dado_in and display_val hold their values until the next capture; they are never cleared except by reset.
- enter, wait_in and wait_out are registered, with no combinational path from inputs.
- Reset mid-handshake: enter drops immediately (async). A key held through reset yields a press_edge after debounce, but it is accepted only if a request is pending.

Optional Feature:
- Macro IO_SIGN_EXT_EN.
- Defined: dado_in capture sign-extends sw_data from bit SW_W-1 to DATA_W.
- Undefined: zero-extension.
- No other behaviour changes.

Test Plan:
All scenarios use DEBOUNCE_CYC=4.
- Reset assert with key held and controleIN=1 -> enter=0, dado_in=0, display_val=0, wait_in=0, wait_out=0 immediately, before any clock edge.
- IN handshake:
  - Stimulus: controleIN=1, sw_data=16'h8005, key_raw low for 12 cycles, then high.
  - Response: wait_in=1; enter rises 7 cycles after the key falls (2 sync + 4 debounce + 1 registered enter); dado_in=32'h00008005, or 32'hFFFF8005 with IO_SIGN_EXT_EN.
  - enter falls after the release debounces; FSM back in IDLE.
- Bounce rejection: in WAIT_IN, key_raw low for 3 cycles then high -> enter stays 0, dado_in unchanged.
- OUT handshake:
  - Stimulus: dado_out=32'h1234ABCD, controleOUT=1.
  - Response: next edge display_val=32'h1234ABCD, wait_out=1.
  - Change dado_out to 0 -> display_val stays 32'h1234ABCD. Press/release -> enter high then low.
- Held-key/idle press:
  - Press in IDLE -> enter stays 0.
  - Assert controleIN while the key is still held -> no capture.
  - Release, then press again -> capture and enter=1.
- Both controleIN and controleOUT high in IDLE -> WAIT_IN entered (wait_in=1, wait_out=0), display_val unchanged.

Source files
------------

// File: rtl/io_handshake_unit.sv
// -----------------------------------------------------------------------------
// io_handshake_unit
// Peripheral-side responder for the control unit's IN/OUT handshake.
//
// The confirm key is synchronised and debounced. A clean press completes a
// pending request. For IN, the switches are captured into dado_in. For OUT,
// the register value is latched onto display_val when the request is seen.
// enter then stays high until the key is released.
//
// Optional build macro: IO_SIGN_EXT_EN
//   Defined   : dado_in sign-extends sw_data from bit SW_W-1.
//   Undefined : dado_in zero-extends sw_data.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   reset        asynchronous, active-high reset
//   controleIN   control unit requests an input word (level)
//   controleOUT  control unit requests an output word (level)
//   sw_data      raw board switches (quasi-static)
//   key_raw      raw confirm key, active-low, asynchronous
//   dado_out     register-bank value to display
//   enter        handshake level back to the control unit
//   dado_in      captured input word for the register write mux
//   display_val  latched output word for the display driver
//   wait_in      LED, input awaited
//   wait_out     LED, output awaited
// -----------------------------------------------------------------------------
module io_handshake_unit #(
   parameter int DATA_W       = 32,
   parameter int SW_W         = 16,
   parameter int DEBOUNCE_CYC = 50000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              controleIN,
   input  logic              controleOUT,
   input  logic [SW_W-1:0]   sw_data,
   input  logic              key_raw,
   input  logic [DATA_W-1:0] dado_out,
   output logic              enter,
   output logic [DATA_W-1:0] dado_in,
   output logic [DATA_W-1:0] display_val,
   output logic              wait_in,
   output logic              wait_out
);

   localparam int              CNT_W   = $clog2(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_IN,
      S_WAIT_OUT,
      S_WAIT_REL
   } state_t;

   // Key conditioning
   logic             r_sync1;
   logic             r_sync2;
   logic             r_key_stable;
   logic             r_key_prev;
   logic [CNT_W-1:0] r_db_cnt;
   logic             w_pressed_sync;
   logic             w_press_edge;
   logic             w_release_edge;

   // Handshake state and outputs
   state_t            r_state;
   logic              r_enter;
   logic              r_wait_in;
   logic              r_wait_out;
   logic [DATA_W-1:0] r_dado_in;
   logic [DATA_W-1:0] r_display_val;

   state_t            w_state_next;
   logic              w_enter_next;
   logic              w_wait_in_next;
   logic              w_wait_out_next;
   logic [DATA_W-1:0] w_dado_in_next;
   logic [DATA_W-1:0] w_display_next;
   logic [DATA_W-1:0] w_sw_ext;

   // The key is active-low, so the synchronisers idle high ("released").
   assign w_pressed_sync = ~r_sync2;
   assign w_press_edge   =  r_key_stable & ~r_key_prev;
   assign w_release_edge = ~r_key_stable &  r_key_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1      <= 1'b1;
         r_sync2      <= 1'b1;
         r_key_stable <= 1'b0;
         r_key_prev   <= 1'b0;
         r_db_cnt     <= '0;
      end else begin
         r_sync1    <= key_raw;
         r_sync2    <= r_sync1;
         r_key_prev <= r_key_stable;
         // Any return to agreement restarts the count, so a glitch shorter
         // than DEBOUNCE_CYC cycles never reaches key_stable.
         if (w_pressed_sync != r_key_stable) begin
            if (r_db_cnt == CNT_MAX) begin
               r_key_stable <= w_pressed_sync;
               r_db_cnt     <= '0;
            end else begin
               r_db_cnt <= r_db_cnt + CNT_W'(1);
            end
         end else begin
            r_db_cnt <= '0;
         end
      end
   end

   // Extend the switch word to the datapath width.
   always_comb begin
`ifdef IO_SIGN_EXT_EN
      w_sw_ext = {DATA_W{sw_data[SW_W-1]}};
`else
      w_sw_ext = '0;
`endif
      w_sw_ext[SW_W-1:0] = sw_data;
   end

   always_comb begin
      w_state_next   = r_state;
      w_enter_next   = r_enter;
      w_dado_in_next = r_dado_in;
      w_display_next = r_display_val;
      case (r_state)
         S_IDLE: begin
            // A press seen here is dropped. A key already held when a
            // request arrives therefore needs a release and a fresh press.
            w_enter_next = 1'b0;
            if (controleIN) begin
               w_state_next = S_WAIT_IN;
            end else if (controleOUT) begin
               w_state_next   = S_WAIT_OUT;
               w_display_next = dado_out;
            end
         end
         S_WAIT_IN: begin
            if (!controleIN) begin
               w_state_next = S_IDLE;
            end else if (w_press_edge) begin
               w_dado_in_next = w_sw_ext;
               w_enter_next   = 1'b1;
               w_state_next   = S_WAIT_REL;
            end
         end
         S_WAIT_OUT: begin
            if (!controleOUT) begin
               w_state_next = S_IDLE;
            end else if (w_press_edge) begin
               w_enter_next = 1'b1;
               w_state_next = S_WAIT_REL;
            end
         end
         S_WAIT_REL: begin
            // The request line is ignored here. Only the release matters.
            if (w_release_edge) begin
               w_enter_next = 1'b0;
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_enter_next = 1'b0;
         end
      endcase
      // The LEDs follow the next state, so they are registered alongside it.
      w_wait_in_next  = (w_state_next == S_WAIT_IN);
      w_wait_out_next = (w_state_next == S_WAIT_OUT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_enter       <= 1'b0;
         r_wait_in     <= 1'b0;
         r_wait_out    <= 1'b0;
         r_dado_in     <= '0;
         r_display_val <= '0;
      end else begin
         r_state       <= w_state_next;
         r_enter       <= w_enter_next;
         r_wait_in     <= w_wait_in_next;
         r_wait_out    <= w_wait_out_next;
         r_dado_in     <= w_dado_in_next;
         r_display_val <= w_display_next;
      end
   end

   assign enter       = r_enter;
   assign wait_in     = r_wait_in;
   assign wait_out    = r_wait_out;
   assign dado_in     = r_dado_in;
   assign display_val = r_display_val;

endmodule

// File: tb/tb_io_handshake_unit.sv
// -----------------------------------------------------------------------------
// tb_io_handshake_unit
// Directed bench for io_handshake_unit, built with DEBOUNCE_CYC = 4.
//
// Each deliberate key press pushes the expected completion into a queue. The
// expected completion holds dado_in, display_val and the cycle in which enter
// should rise. A separate monitor pops one entry on every rising edge of
// enter and compares it. Static conditions are checked inline.
// -----------------------------------------------------------------------------
module tb_io_handshake_unit;

   localparam int DATA_W = 32;
   localparam int SW_W   = 16;
   localparam int DB     = 4;
   localparam int LAT    = 2 + DB + 1;   // key edge -> enter change

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              controleIN = 1'b0;
   logic              controleOUT = 1'b0;
   logic [SW_W-1:0]   sw_data = '0;
   logic              key_raw = 1'b1;
   logic [DATA_W-1:0] dado_out = '0;
   logic              enter;
   logic [DATA_W-1:0] dado_in;
   logic [DATA_W-1:0] display_val;
   logic              wait_in;
   logic              wait_out;

   io_handshake_unit #(.DATA_W(DATA_W), .SW_W(SW_W), .DEBOUNCE_CYC(DB)) dut (
      .clk(clk), .reset(reset), .controleIN(controleIN), .controleOUT(controleOUT),
      .sw_data(sw_data), .key_raw(key_raw), .dado_out(dado_out), .enter(enter),
      .dado_in(dado_in), .display_val(display_val), .wait_in(wait_in), .wait_out(wait_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] exp_in;
      logic [DATA_W-1:0] exp_disp;
      int                exp_cyc;
   } txn_t;

   txn_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;
   logic prev_enter = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] ext(input logic [SW_W-1:0] s);
`ifdef IO_SIGN_EXT_EN
      return {{(DATA_W-SW_W){s[SW_W-1]}}, s};
`else
      return {{(DATA_W-SW_W){1'b0}}, s};
`endif
   endfunction

   // A press whose completion is expected: queue it, then hold the key
   // for hold cycles and release it.
   task automatic expect_press(input logic [DATA_W-1:0] ein, input logic [DATA_W-1:0] edisp,
                               input int hold);
      txn_t t;
      t.exp_in   = ein;
      t.exp_disp = edisp;
      t.exp_cyc  = cyc + LAT;
      exp_q.push_back(t);
      key_raw = 1'b0;
      tick(hold);
   endtask

   // Monitor: every rising enter is one completed handshake.
   always @(negedge clk) begin
      if (mon_en && !reset && enter && !prev_enter) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mon_unexpected_enter actual=1 required=0 cyc=%0d", cyc);
         end else begin
            txn_t t;
            t = exp_q.pop_front();
            check("mon_dado_in", dado_in, t.exp_in);
            check("mon_display_val", display_val, t.exp_disp);
            check("mon_enter_cycle", DATA_W'(cyc), DATA_W'(t.exp_cyc));
         end
      end
      prev_enter <= enter;
   end

   initial begin
      // Let the design run with the key held and a request pending. Then
      // assert reset between clock edges.
      key_raw    = 1'b0;
      controleIN = 1'b1;
      tick(3);
      #2 reset = 1'b1;
      #1;
      check("rst_enter", DATA_W'(enter), 0);
      check("rst_dado_in", dado_in, 0);
      check("rst_display_val", display_val, 0);
      check("rst_wait_in", DATA_W'(wait_in), 0);
      check("rst_wait_out", DATA_W'(wait_out), 0);
      tick(3);
      controleIN = 1'b0;
      reset      = 1'b0;
      mon_en     = 1'b1;
      // A key held through reset debounces into a press while idle.
      // That press must be discarded.
      tick(10);
      check("held_through_reset_enter", DATA_W'(enter), 0);
      key_raw = 1'b1;
      tick(10);

      // IN handshake
      controleIN = 1'b1;
      sw_data    = 16'h8005;
      tick(2);
      check("in_wait_in", DATA_W'(wait_in), 1);
      check("in_wait_out", DATA_W'(wait_out), 0);
      expect_press(ext(16'h8005), 0, 12);
      key_raw    = 1'b1;
      controleIN = 1'b0;
      tick(10);
      check("in_enter_fall", DATA_W'(enter), 0);
      check("in_back_idle", DATA_W'(wait_in), 0);
      check("in_dado_in_hold", dado_in, ext(16'h8005));

      // Bounce rejection: a 3-cycle low pulse is shorter than the debounce.
      controleIN = 1'b1;
      sw_data    = 16'h1111;
      tick(2);
      key_raw = 1'b0;
      tick(3);
      key_raw = 1'b1;
      tick(10);
      check("bounce_enter", DATA_W'(enter), 0);
      check("bounce_dado_in", dado_in, ext(16'h8005));
      check("bounce_still_waiting", DATA_W'(wait_in), 1);
      controleIN = 1'b0;
      tick(2);
      check("req_drop_idle", DATA_W'(wait_in), 0);

      // OUT handshake
      dado_out    = 32'h1234ABCD;
      controleOUT = 1'b1;
      tick(1);
      check("out_display_capture", display_val, 32'h1234ABCD);
      check("out_wait_out", DATA_W'(wait_out), 1);
      dado_out = 32'h0;
      tick(2);
      check("out_display_hold", display_val, 32'h1234ABCD);
      expect_press(ext(16'h8005), 32'h1234ABCD, 8);
      key_raw     = 1'b1;
      controleOUT = 1'b0;
      tick(10);
      check("out_enter_fall", DATA_W'(enter), 0);
      check("out_back_idle", DATA_W'(wait_out), 0);

      // Held key: a press while idle is dropped, and a request made while
      // the key is held does not capture.
      key_raw = 1'b0;
      tick(10);
      check("idle_press_enter", DATA_W'(enter), 0);
      controleIN = 1'b1;
      sw_data    = 16'h00A5;
      tick(10);
      check("held_req_enter", DATA_W'(enter), 0);
      check("held_req_dado_in", dado_in, ext(16'h8005));
      check("held_req_wait_in", DATA_W'(wait_in), 1);
      key_raw = 1'b1;
      tick(10);
      check("held_release_enter", DATA_W'(enter), 0);
      expect_press(32'h000000A5, 32'h1234ABCD, 8);
      key_raw    = 1'b1;
      controleIN = 1'b0;
      tick(10);
      check("fresh_press_enter_fall", DATA_W'(enter), 0);

      // Both requests high: IN wins and the display is untouched.
      dado_out    = 32'hDEADBEEF;
      controleIN  = 1'b1;
      controleOUT = 1'b1;
      tick(2);
      check("both_wait_in", DATA_W'(wait_in), 1);
      check("both_wait_out", DATA_W'(wait_out), 0);
      check("both_display_val", display_val, 32'h1234ABCD);
      controleIN  = 1'b0;
      controleOUT = 1'b0;
      tick(4);

      check("all_handshakes_seen", DATA_W'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
